// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA frame-buffer scan-out block.
//   - Default 640x480@60 timing values and the sync window positions derived
//     from them.
//   - Counter / address / pixel widths.
//   - The 2-bit scale-mode encoding and a decoder for the two rez inputs.
//   - The bundle of per-pixel control flags that travels down the delay pipe.
// -----------------------------------------------------------------------------
package vga_pkg;

    // Default horizontal timing, in pixels
    localparam int H_VIS_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;

    // Default vertical timing, in lines
    localparam int V_VIS_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    // Derived totals and sync windows for the default timing
    localparam int H_TOTAL      = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
    localparam int V_TOTAL      = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525
    localparam int H_SYNC_START = H_VIS_DEF + H_FP_DEF;                          // 656
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;                 // 751
    localparam int V_SYNC_START = V_VIS_DEF + V_FP_DEF;                          // 490
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;                 // 491

    localparam int CNT_W  = 10;   // enough for 0..799 and 0..524
    localparam int ADDR_W = 17;   // enough for 320*240-1 = 76799
    localparam int PIX_W  = 12;   // RGB444

    // Scale mode held for a whole frame
    typedef enum logic [1:0] {
        SCALE_2X = 2'b01,
        SCALE_4X = 2'b10
    } scale_mode_e;

    // Control flags that must stay aligned with the pixel data
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic visible;
        logic frame_start;
    } vga_ctl_t;

    localparam vga_ctl_t CTL_RESET = '{hsync: 1'b1, vsync: 1'b1, visible: 1'b0, frame_start: 1'b0};

    // rez = {rez_160x120, rez_320x240}. 160x120 wins when both are set;
    // neither set falls back to the 320x240 layout.
    function automatic scale_mode_e decode_mode(input logic [1:0] rez);
        case (rez)
            2'b10, 2'b11: decode_mode = SCALE_4X;
            default:      decode_mode = SCALE_2X;
        endcase
    endfunction

endpackage

// File: rtl/vga_fb_reader_if.sv
// -----------------------------------------------------------------------------
// vga_fb_reader_if
// Read port of the dual-port frame buffer.
//   fb_addr : read address (driven by the reader)
//   fb_data : RGB444 pixel, returned a fixed latency after fb_addr
// Modports: master = scan-out reader, slave = frame-buffer memory.
// -----------------------------------------------------------------------------
interface vga_fb_reader_if;
    import vga_pkg::*;

    logic [ADDR_W-1:0] fb_addr;
    logic [PIX_W-1:0]  fb_data;

    modport master (output fb_addr, input  fb_data);
    modport slave  (input  fb_addr, output fb_data);

endinterface

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Free-running raster counters and the undelayed ("stage 0") control flags.
// Ports:
//   clk25   in   pixel clock
//   rst     in   synchronous active-high reset
//   hcnt    out  horizontal position, 0 .. H_total-1
//   vcnt    out  vertical position,   0 .. V_total-1
//   raw_ctl out  active-low syncs, visible flag and frame-start strobe
//                for the current (hcnt, vcnt)
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VIS  = H_VIS_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int V_VIS  = V_VIS_DEF,
    parameter int V_FP   = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF
) (
    input  logic             clk25,
    input  logic             rst,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output vga_ctl_t         raw_ctl
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

    always_ff @(posedge clk25) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    always_comb begin
        raw_ctl             = CTL_RESET;
        raw_ctl.hsync       = !((hcnt >= HS_START) && (hcnt <= HS_END));
        raw_ctl.vsync       = !((vcnt >= VS_START) && (vcnt <= VS_END));
        raw_ctl.visible     = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
        raw_ctl.frame_start = (hcnt == '0) && (vcnt == '0);
    end

endmodule

// File: rtl/vga_fb_reader.sv
// -----------------------------------------------------------------------------
// vga_fb_reader
// Scan-out stage: reads a 320x240 (2x) or 160x120 (4x) RGB444 frame from the
// frame buffer and drives 640x480@60 VGA with pixel replication. Also emits a
// frame_start pulse aligned with the first visible pixel on the pins.
// Ports:
//   clk25        in   pixel clock
//   rst          in   synchronous active-high reset
//   rez_160x120  in   stored frame is 160x120 (4x replication)
//   rez_320x240  in   stored frame is 320x240 (2x replication)
//   fb           master port of the frame-buffer read interface
//   vga_red/green/blue  out  4-bit colour, forced to 0 in blanking
//   vga_hsync/vsync     out  active-low syncs
//   frame_start         out  one-cycle pulse with the first visible pixel
// Counter-to-pin latency is RD_LAT+1 for every output.
// -----------------------------------------------------------------------------
module vga_fb_reader
    import vga_pkg::*;
#(
    parameter int H_VIS  = H_VIS_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int V_VIS  = V_VIS_DEF,
    parameter int V_FP   = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF,
    parameter int RD_LAT = 1
) (
    input  logic             clk25,
    input  logic             rst,
    input  logic             rez_160x120,
    input  logic             rez_320x240,
    vga_fb_reader_if.master  fb,
    output logic [3:0]       vga_red,
    output logic [3:0]       vga_green,
    output logic [3:0]       vga_blue,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic             frame_start
);

    localparam logic [CNT_W-1:0]  H_LAST      = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0]  V_LAST      = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0]  H_VIS_LAST  = CNT_W'(H_VIS - 1);
    localparam logic [CNT_W-1:0]  V_VIS_LAST  = CNT_W'(V_VIS - 1);
    localparam logic [ADDR_W-1:0] ROW_W_2X    = ADDR_W'(H_VIS / 2);
    localparam logic [ADDR_W-1:0] ROW_W_4X    = ADDR_W'(H_VIS / 4);

    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  vcnt;
    vga_ctl_t          raw_ctl;

    scale_mode_e       mode_q;
    logic [1:0]        col_sub;
    logic [1:0]        line_sub;
    logic [1:0]        sub_last;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] row_w;
    logic [ADDR_W-1:0] next_row_base;

    vga_ctl_t          ctl_pipe [RD_LAT];
    vga_ctl_t          ctl_d;

    vga_timing_gen #(
        .H_VIS  (H_VIS),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_VIS  (V_VIS),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk25   (clk25),
        .rst     (rst),
        .hcnt    (hcnt),
        .vcnt    (vcnt),
        .raw_ctl (raw_ctl)
    );

    always_comb begin
        sub_last      = 2'd1;
        row_w         = ROW_W_2X;
        if (mode_q == SCALE_4X) begin
            sub_last = 2'd3;
            row_w    = ROW_W_4X;
        end
        next_row_base = row_base + row_w;
    end

    // Incremental address generator. fb_addr always holds the address of the
    // pixel at the current (hcnt, vcnt). The mode is latched at the end of the
    // first pixel of a frame; col_sub is still 0 there, so the switch never
    // disturbs the first stored column. The increment on the last visible
    // column is suppressed so the address stays within the stored frame
    // through blanking.
    always_ff @(posedge clk25) begin
        if (rst) begin
            mode_q     <= SCALE_2X;
            fb.fb_addr <= '0;
            row_base   <= '0;
            col_sub    <= '0;
            line_sub   <= '0;
        end else begin
            if ((hcnt == '0) && (vcnt == '0)) begin
                mode_q <= decode_mode({rez_160x120, rez_320x240});
            end

            if (raw_ctl.visible) begin
                if (col_sub == sub_last) begin
                    col_sub <= '0;
                    if (hcnt != H_VIS_LAST) begin
                        fb.fb_addr <= fb.fb_addr + 1'b1;
                    end
                end else begin
                    col_sub <= col_sub + 1'b1;
                end
            end

            if (hcnt == H_LAST) begin
                col_sub <= '0;
                if (vcnt == V_LAST) begin
                    row_base   <= '0;
                    fb.fb_addr <= '0;
                    line_sub   <= '0;
                end else if (vcnt < V_VIS_LAST) begin
                    if (line_sub == sub_last) begin
                        row_base   <= next_row_base;
                        fb.fb_addr <= next_row_base;
                        line_sub   <= '0;
                    end else begin
                        fb.fb_addr <= row_base;
                        line_sub   <= line_sub + 1'b1;
                    end
                end
            end
        end
    end

    // Control flags wait RD_LAT cycles so they meet the pixel coming back
    // from the frame buffer at the output register.
    always_ff @(posedge clk25) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                ctl_pipe[i] <= CTL_RESET;
            end
        end else begin
            ctl_pipe[0] <= raw_ctl;
            for (int i = 1; i < RD_LAT; i++) begin
                ctl_pipe[i] <= ctl_pipe[i-1];
            end
        end
    end

    assign ctl_d = ctl_pipe[RD_LAT-1];

    always_ff @(posedge clk25) begin
        if (rst) begin
            vga_red     <= '0;
            vga_green   <= '0;
            vga_blue    <= '0;
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            vga_red     <= ctl_d.visible ? fb.fb_data[11:8] : 4'h0;
            vga_green   <= ctl_d.visible ? fb.fb_data[7:4]  : 4'h0;
            vga_blue    <= ctl_d.visible ? fb.fb_data[3:0]  : 4'h0;
            vga_hsync   <= ctl_d.hsync;
            vga_vsync   <= ctl_d.vsync;
            frame_start <= ctl_d.frame_start;
        end
    end

endmodule

// File: tb/tb_vga_fb_reader.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_reader
// Scoreboard bench for vga_fb_reader using a reduced raster (64x48 visible,
// 80x55 total) so that many whole frames fit in a short run. The frame-buffer
// model returns the low 12 bits of the address after RD_LAT cycles.
// A reference model computes, from raster position and the frame's mode, the
// pixel that belongs on the pins and pushes it into a queue; a monitor pops
// one entry per cycle and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_vga_fb_reader;

    localparam int HV = 64, HFP = 4, HSY = 8, HBP = 4;
    localparam int VV = 48, VFP = 2, VSY = 2, VBP = 3;
    localparam int HT = HV + HFP + HSY + HBP;   // 80
    localparam int VT = VV + VFP + VSY + VBP;   // 55
    localparam int FRAME = HT * VT;             // 4400
    localparam int RD_LAT = 1;

    typedef struct {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
        logic       fs;
    } exp_t;

    logic       clk25 = 1'b0;
    logic       rst;
    logic       rez_160x120;
    logic       rez_320x240;
    logic [3:0] vga_red;
    logic [3:0] vga_green;
    logic [3:0] vga_blue;
    logic       vga_hsync;
    logic       vga_vsync;
    logic       frame_start;

    vga_fb_reader_if fb_bus ();

    int compared   = 0;
    int mismatched = 0;

    exp_t exp_q[$];

    vga_fb_reader #(
        .H_VIS (HV), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_VIS (VV), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk25       (clk25),
        .rst         (rst),
        .rez_160x120 (rez_160x120),
        .rez_320x240 (rez_320x240),
        .fb          (fb_bus),
        .vga_red     (vga_red),
        .vga_green   (vga_green),
        .vga_blue    (vga_blue),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .frame_start (frame_start)
    );

    always #5 clk25 = ~clk25;

    // Frame-buffer model: data = address[11:0], RD_LAT cycles later
    logic [16:0] addr_pipe [RD_LAT];
    always @(posedge clk25) begin
        addr_pipe[0] <= fb_bus.fb_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            addr_pipe[i] <= addr_pipe[i-1];
        end
    end
    assign fb_bus.fb_data = addr_pipe[RD_LAT-1][11:0];

    function automatic int scale_of(input bit m4);
        return m4 ? 4 : 2;
    endfunction

    // Stored-frame address shown at screen position (h, v)
    function automatic int model_addr(input int h, input int v, input bit m4);
        int s;
        s = scale_of(m4);
        return (v / s) * (HV / s) + h / s;
    endfunction

    function automatic int model_max_addr(input bit m4);
        int s;
        s = scale_of(m4);
        return (VV / s) * (HV / s) - 1;
    endfunction

    function automatic exp_t model_pixel(input int h, input int v, input bit m4);
        exp_t e;
        int   a;
        bit   vis;
        vis  = (h < HV) && (v < VV);
        a    = model_addr(h, v, m4);
        e.r  = vis ? 4'(a >> 8) : 4'h0;
        e.g  = vis ? 4'(a >> 4) : 4'h0;
        e.b  = vis ? 4'(a)      : 4'h0;
        e.hs = !((h >= HV + HFP) && (h < HV + HFP + HSY));
        e.vs = !((v >= VV + VFP) && (v < VV + VFP + VSY));
        e.fs = (h == 0) && (v == 0);
        return e;
    endfunction

    function automatic exp_t reset_pixel();
        exp_t e;
        e.r  = 4'h0;
        e.g  = 4'h0;
        e.b  = 4'h0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        e.fs = 1'b0;
        return e;
    endfunction

    // Reference model: tracks the raster position as a cycle count since the
    // last reset edge and predicts what reaches the pins RD_LAT+1 cycles on.
    int m_n     = 0;
    bit m_armed = 1'b0;
    bit m_4x    = 1'b0;

    initial begin
        int h;
        int v;
        int a;
        forever begin
            @(posedge clk25);
            #1;
            if (rst === 1'b1) begin
                exp_q.delete();
                repeat (RD_LAT + 1) exp_q.push_back(reset_pixel());
                m_n     = 0;
                m_armed = 1'b1;
            end else if (m_armed) begin
                m_n++;
            end
            if (m_armed) begin
                h = m_n % HT;
                v = (m_n / HT) % VT;
                if (h == 0 && v == 0) begin
                    m_4x = rez_160x120;
                end
                exp_q.push_back(model_pixel(h, v, m_4x));
                compared++;
                if ((h < HV) && (v < VV)) begin
                    a = model_addr(h, v, m_4x);
                    if (fb_bus.fb_addr !== 17'(a)) begin
                        mismatched++;
                        $display("[TB] FAIL fb_addr h=%0d v=%0d got %0d expected %0d", h, v, fb_bus.fb_addr, a);
                    end
                end else begin
                    a = model_max_addr(m_4x);
                    if ($isunknown(fb_bus.fb_addr) || (int'(fb_bus.fb_addr) > a)) begin
                        mismatched++;
                        $display("[TB] FAIL fb_addr_bound h=%0d v=%0d got %0d limit %0d", h, v, fb_bus.fb_addr, a);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input exp_t e);
        compared++;
        if ((vga_red !== e.r) || (vga_green !== e.g) || (vga_blue !== e.b)) begin
            mismatched++;
            $display("[TB] FAIL rgb t=%0t got %h%h%h expected %h%h%h",
                     $time, vga_red, vga_green, vga_blue, e.r, e.g, e.b);
        end
        compared++;
        if ((vga_hsync !== e.hs) || (vga_vsync !== e.vs) || (frame_start !== e.fs)) begin
            mismatched++;
            $display("[TB] FAIL sync t=%0t got hs=%b vs=%b fs=%b expected hs=%b vs=%b fs=%b",
                     $time, vga_hsync, vga_vsync, frame_start, e.hs, e.vs, e.fs);
        end
    endtask

    // Monitor: one output sample per cycle, away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk25);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic m160, input logic m320, input int ncyc);
        rst         = r;
        rez_160x120 = m160;
        rez_320x240 = m320;
        repeat (ncyc) @(negedge clk25);
    endtask

    // Stimulus: rez changes land mid-frame (line 2 or later) so the model and
    // the DUT agree on which frame they belong to.
    initial begin
        int   pos;
        int   target;
        logic cur160;
        logic cur320;
        cur160 = 1'b0;
        cur320 = 1'b0;
        $display("[TB] start");
        applyStimulus(1'b1, 1'b0, 1'b0, 3);
        pos = 0;
        for (int f = 0; f < 10; f++) begin
            target = f * FRAME + (2 + int'($urandom_range(0, VV))) * HT + int'($urandom_range(0, HT - 1));
            applyStimulus(1'b0, cur160, cur320, target - pos);
            pos = target;
            case (f)
                0:       {cur160, cur320} = 2'b10;
                1:       {cur160, cur320} = 2'b01;
                2:       {cur160, cur320} = 2'b11;
                3:       {cur160, cur320} = 2'b00;
                default: {cur160, cur320} = 2'($urandom_range(0, 3));
            endcase
        end
        target = 10 * FRAME + 20 * HT + 30;
        applyStimulus(1'b0, cur160, cur320, target - pos);
        $display("[TB] mid-frame reset");
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 2 * FRAME + 20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
